// File: rtl/apb4_pkg.sv
// Shared types and helpers for the APB4 completer register bank.
`ifndef APB4_ADDR_W
`define APB4_ADDR_W 32
`endif
`ifndef APB4_DATA_W
`define APB4_DATA_W 32
`endif

package apb4_pkg;

  localparam int unsigned APB_ADDR_W = `APB4_ADDR_W;
  localparam int unsigned APB_DATA_W = `APB4_DATA_W;
  localparam int unsigned APB_STRB_W = APB_DATA_W / 8;
  localparam int unsigned APB_PROT_W = 3;
  localparam int unsigned APB_CNT_W  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Request captured in the setup phase and held for the whole access phase.
  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic [APB_PROT_W-1:0] prot;
  } apb_req_t;

  // Number of byte-offset address bits for a given data width.
  function automatic int unsigned clog2_bytes(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb4_regfile.sv
// DEPTH x DATA_WIDTH register storage: synchronous reset, byte-strobed write,
// asynchronous read.
module apb4_regfile #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Clear on reset; otherwise update only the strobed byte lanes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Out-of-range indices (non power-of-two depth) read as zero.
  assign rdata_o = (32'(addr_i) < DEPTH) ? mem_q[addr_i] : '0;

endmodule

// File: rtl/apb4_slave_regbank.sv
// APB4 completer: register bank with byte strobes, programmable wait states,
// privileged region and PSLVERR. Bus widths must match the apb4_pkg widths.
module apb4_slave_regbank
  import apb4_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = APB_ADDR_W,
  parameter int unsigned DATA_WIDTH  = APB_DATA_W,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned PRIV_BASE   = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = clog2_bytes(DATA_WIDTH);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

  apb_state_e            state_q;
  logic [APB_CNT_W-1:0]  cnt_q;
  apb_req_t              req_q;
  apb_req_t              req_d;

  logic [ADDR_WIDTH-1:0] addr_c;
  logic [ADDR_WIDTH-1:0] idx_full_c;
  logic                  err_c;
  logic                  ready_c;
  logic                  we_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  unused_prot_c;

  // Pack the setup-phase bus signals into a request.
  always_comb begin
    req_d       = '0;
    req_d.addr  = APB_ADDR_W'(PADDR);
    req_d.write = PWRITE;
    req_d.wdata = APB_DATA_W'(PWDATA);
    req_d.strb  = APB_STRB_W'(PSTRB);
    req_d.prot  = PPROT;
  end

  // Transfer FSM with wait-state counter and request capture.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            req_q   <= req_d;
            cnt_q   <= APB_CNT_W'(WAIT_STATES);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - APB_CNT_W'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Error decode on the captured request: misaligned, out of range, unprivileged.
  always_comb begin
    addr_c     = ADDR_WIDTH'(req_q.addr);
    idx_full_c = addr_c >> LSB;
    err_c      = ((addr_c & ALIGN_MASK) != '0)
              || (64'(idx_full_c) >= 64'(DEPTH))
              || ((64'(idx_full_c) >= 64'(PRIV_BASE)) && !req_q.prot[0]);
  end

  assign unused_prot_c = ^req_q.prot[2:1];

  assign ready_c = (state_q == ACCESS) && (cnt_q == '0);
  assign we_c    = ready_c && PSEL && req_q.write && !err_c;

  apb4_regfile #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .we_i    (we_c),
    .addr_i  (idx_full_c[IDX_W-1:0]),
    .wdata_i (DATA_WIDTH'(req_q.wdata)),
    .wstrb_i (STRB_W'(req_q.strb)),
    .rdata_o (rdata_c)
  );

  assign PREADY  = ready_c;
  assign PSLVERR = ready_c && err_c;
  assign PRDATA  = (ready_c && !req_q.write && !err_c) ? rdata_c : '0;

endmodule

// File: doc/apb4_slave_regbank.md
Name: apb4_slave_regbank

Overview:
- Parametrised synthesisable APB4 completer: register bank with byte strobes, programmable wait states, protection checking and PSLVERR generation.
- It is the DUT-side counterpart that the APB4 slave VIP environment (driver/monitor/scoreboard) connects to.
- Generalises the fixed 32-bit slave to configurable address width, data width, depth, wait states and a privileged-access region.

Parameters:
- ADDR_WIDTH, 32, PADDR width in bits.
- DATA_WIDTH, 32, PWDATA/PRDATA width in bits; must be 8, 16, 32 or 64.
- DEPTH, 16, number of DATA_WIDTH-bit registers.
- WAIT_STATES, 0, PREADY-low cycles inserted per transfer (0..15).
- PRIV_BASE, 8, first register index that requires privileged access (PPROT[0]=1); set to DEPTH to disable.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PPROT  in  3  protection; only bit 0 (privileged) is checked.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error; valid only while PREADY=1.

Behaviour:
- Reset: when PRESET=1 at a rising edge, FSM goes to IDLE, wait counter to 0, all registers to 0, captured request to 0. PRDATA=0, PREADY=0, PSLVERR=0 from the following cycle. Reset mid-transfer aborts the transfer with no write.
- Derived values: LSB = log2(DATA_WIDTH/8); index = PADDR >> LSB.
- FSM IDLE:
  - On PSEL=1, PENABLE=0 (setup phase): capture PADDR, PWRITE, PWDATA, PSTRB and PPROT; load cnt with WAIT_STATES; go to ACCESS.
  - PENABLE=1 seen in IDLE without a preceding setup is ignored; stay in IDLE.
- FSM ACCESS:
  - PSEL=0: abort, go to IDLE, no write.
  - cnt != 0: decrement cnt; PREADY=0.
  - cnt == 0: PREADY=1 (combinational from state and cnt); next state IDLE.
- Latency: PREADY rises in access cycle number WAIT_STATES+1. With WAIT_STATES=0, every transfer takes 2 cycles.
- Back-to-back transfers: the setup of the next transfer arrives the cycle after completion, and IDLE accepts it.
- Error is evaluated on the captured request. err = any of:
  - PADDR[LSB-1:0] != 0 (misaligned);
  - index >= DEPTH;
  - index >= PRIV_BASE and PPROT[0]=0.
- While PREADY=1, PSLVERR = err; otherwise PSLVERR=0.
- Write commit: on the completing edge when PWRITE=1 and err=0. For each byte lane i with PSTRB[i]=1, reg[index] byte i takes PWDATA byte i; other lanes are unchanged. PSTRB=0 is a legal no-op write.
- Error write: no register changes.
- Read: while PREADY=1 and PWRITE=0, PRDATA = reg[index], or 0 if err. PRDATA=0 at all other times, including during writes. PSTRB is ignored on reads.
- Address bits above the index range are not decoded beyond the DEPTH check.

Decomposition:
- Package apb4_pkg holds:
  - apb_state_e enum (IDLE, ACCESS);
  - apb_req_t struct (addr, write, wdata, strb, prot), parametrised via the codebase width macros;
  - localparam function clog2_bytes(DATA_WIDTH).
- One sub-module, apb4_regfile: DEPTH x DATA_WIDTH storage with synchronous reset, byte-strobed write port and asynchronous read port.
- FSM, wait counter and error decode stay in the top module.

Test Plan:
- Basic write/read (WAIT_STATES=0): write 0xDEADBEEF to 0x04 with PSTRB=4'hF, then read 0x04 -> PRDATA=0xDEADBEEF; PREADY high on the 2nd cycle of each transfer; PSLVERR=0.
- Byte strobes: write 0x11223344 to 0x08 with PSTRB=4'hF, then 0xAABBCCDD with PSTRB=4'b0101 -> read 0x08 returns 0x11BB33DD.
- Wait states (WAIT_STATES=3): any transfer -> PREADY low for 3 access cycles and high on the 4th; total 5 cycles; PRDATA=0 before PREADY.
- Errors:
  - read 0x40 with DEPTH=16 -> PSLVERR=1, PRDATA=0;
  - write to 0x06 -> PSLVERR=1, no register change;
  - write 0x5 to index 9 (0x24) with PPROT=3'b000 -> PSLVERR=1 and reg unchanged; with PPROT=3'b001 -> success.
- Abort/reset: with WAIT_STATES=2, drop PSEL during the 1st wait cycle of a write of 0xCAFE to 0x0C -> FSM back to IDLE, read 0x0C returns the old value. Assert PRESET mid-transfer -> the next cycle PREADY=0 and PSLVERR=0, and all registers read 0.
- Back-to-back: 8 consecutive writes to 0x00..0x1C with no idle cycles, then 8 reads -> each read returns its written value, and each transfer completes in WAIT_STATES+2 cycles.
